// File: rtl/exc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exc_ctrl_pkg
//   Shared CPU definitions used by the exception sequencer and its neighbours:
//   - encoder exception codes as produced by the MEM-stage priority encoder
//   - CP0 Cause.ExcCode field values
//   - CP0 Status bit indices
//   - the sequencer state encoding
//   No ports (package).
// ---------------------------------------------------------------------------
package exc_ctrl_pkg;

  // Encoder codes from the MEM stage (4 bits, 14..15 never mean anything).
  localparam logic [3:0] EXC_NONE = 4'd0;
  localparam logic [3:0] EXC_INT0 = 4'd1;
  localparam logic [3:0] EXC_INT1 = 4'd2;
  localparam logic [3:0] EXC_INT2 = 4'd3;
  localparam logic [3:0] EXC_INT3 = 4'd4;
  localparam logic [3:0] EXC_INT4 = 4'd5;
  localparam logic [3:0] EXC_INT5 = 4'd6;
  localparam logic [3:0] EXC_INT6 = 4'd7;
  localparam logic [3:0] EXC_INT7 = 4'd8;
  localparam logic [3:0] EXC_SYS  = 4'd9;
  localparam logic [3:0] EXC_RI   = 4'd10;
  localparam logic [3:0] EXC_TR   = 4'd11;
  localparam logic [3:0] EXC_OV   = 4'd12;
  localparam logic [3:0] EXC_ERET = 4'd13;

  // Cause.ExcCode values written to CP0.
  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_RI  = 5'd10;
  localparam logic [4:0] EXCCODE_OV  = 5'd12;
  localparam logic [4:0] EXCCODE_TR  = 5'd13;

  // Status register bit positions.
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Codes 14 and 15 are encoder garbage and behave exactly like EXC_NONE.
  function automatic logic isLegalCode(input logic [3:0] code);
    return (code >= EXC_INT0) && (code <= EXC_ERET);
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// exc_ctrl_if
//   Bundles every non-clock/reset signal of the exception sequencer.
//   slave  : the sequencer itself (consumes MEM/CP0/fetch info, drives the
//            flush, CP0 update and fetch redirect)
//   master : the surrounding pipeline (MEM encoder, CP0, fetch PC register)
//   Signals:
//     exc_code_i   encoder code        exc_pc_i   MEM-stage PC
//     exc_bd_i     delay-slot flag     cp0_status_i / cp0_epc_i  CP0 state
//     pc_ack_i     fetch accepted redirect
//     busy_o flush_o cp0_we_o epc_we_o epc_o cause_exccode_o cause_bd_o
//     exl_set_o exl_clr_o pc_we_o new_pc_o
// ---------------------------------------------------------------------------
interface exc_ctrl_if;
  import exc_ctrl_pkg::*;

  logic [3:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_epc_i;
  logic        pc_ack_i;

  logic        busy_o;
  logic        flush_o;
  logic        cp0_we_o;
  logic        epc_we_o;
  logic [31:0] epc_o;
  logic [4:0]  cause_exccode_o;
  logic        cause_bd_o;
  logic        exl_set_o;
  logic        exl_clr_o;
  logic        pc_we_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  exc_code_i, exc_pc_i, exc_bd_i, cp0_status_i, cp0_epc_i, pc_ack_i,
    output busy_o, flush_o, cp0_we_o, epc_we_o, epc_o, cause_exccode_o,
           cause_bd_o, exl_set_o, exl_clr_o, pc_we_o, new_pc_o
  );

  modport master (
    output exc_code_i, exc_pc_i, exc_bd_i, cp0_status_i, cp0_epc_i, pc_ack_i,
    input  busy_o, flush_o, cp0_we_o, epc_we_o, epc_o, cause_exccode_o,
           cause_bd_o, exl_set_o, exl_clr_o, pc_we_o, new_pc_o
  );

endinterface

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl
//   Exception/interrupt sequencer. Takes the prioritised code from the MEM
//   stage, flushes the pipeline, issues a one-cycle CP0 update (EPC, Cause,
//   Status.EXL) and redirects fetch to the handler vector, or to EPC for ERET.
//   Parameters:
//     EXC_VECTOR    handler entry address
//     FLUSH_CYCLES  cycles flush_o is held (1..15)
//   Ports:
//     clk    clock
//     rst_n  synchronous active-low reset
//     bus    exc_ctrl_if.slave (see interface header for signal list)
//   Every output is a decode of registered state; exc_code_i only reaches
//   the outputs through the state/latch registers.
// ---------------------------------------------------------------------------
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  exc_ctrl_if.slave   bus
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  exc_state_e  state_q,    state_d;
  logic [3:0]  flushCnt_q, flushCnt_d;
  logic [3:0]  code_q,     code_d;
  logic [31:0] pc_q,       pc_d;
  logic        bd_q,       bd_d;
  logic        exl_q,      exl_d;
  logic [31:0] target_q,   target_d;

  logic        busy;
  logic        flush;
  logic        cp0We;
  logic        epcWe;
  logic [31:0] epcData;
  logic [4:0]  excCode;
  logic        causeBd;
  logic        exlSet;
  logic        exlClr;
  logic        pcWe;
  logic [31:0] newPc;

  // Only Status.EXL matters here; the rest of Status is deliberately ignored.
  logic unused_status;
  assign unused_status = ^{bus.cp0_status_i[31:2], bus.cp0_status_i[STATUS_IE]};

  // Encoder code to Cause.ExcCode. All eight interrupt lines share "Int";
  // the handler reads Cause.IP to tell them apart.
  function automatic logic [4:0] mapExcCode(input logic [3:0] code);
    logic [4:0] result;
    result = EXCCODE_INT;
    case (code)
      EXC_SYS: result = EXCCODE_SYS;
      EXC_RI:  result = EXCCODE_RI;
      EXC_TR:  result = EXCCODE_TR;
      EXC_OV:  result = EXCCODE_OV;
      default: result = EXCCODE_INT;
    endcase
    return result;
  endfunction

  // State and latch registers. Reset drops any sequence in flight straight
  // back to IDLE, which also guarantees no late CP0 strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flushCnt_q <= 4'd0;
      code_q     <= EXC_NONE;
      pc_q       <= 32'd0;
      bd_q       <= 1'b0;
      exl_q      <= 1'b0;
      target_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
      code_q     <= code_d;
      pc_q       <= pc_d;
      bd_q       <= bd_d;
      exl_q      <= exl_d;
      target_q   <= target_d;
    end
  end

  // Next-state logic. Everything needed later in the sequence is captured on
  // the accepting edge so the MEM-stage inputs are free to change afterwards;
  // for ERET that includes EPC, so a CP0 write landing during the flush
  // cannot move the return address.
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    code_d     = code_q;
    pc_d       = pc_q;
    bd_d       = bd_q;
    exl_d      = exl_q;
    target_d   = target_q;

    case (state_q)
      ST_IDLE: begin
        if (isLegalCode(bus.exc_code_i)) begin
          state_d    = ST_FLUSH;
          flushCnt_d = 4'd0;
          code_d     = bus.exc_code_i;
          pc_d       = bus.exc_pc_i;
          bd_d       = bus.exc_bd_i;
          exl_d      = bus.cp0_status_i[STATUS_EXL];
          target_d   = (bus.exc_code_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
        end
      end

      ST_FLUSH: begin
        if (flushCnt_q == FLUSH_LAST) begin
          state_d    = ST_REDIRECT;
          flushCnt_d = 4'd0;
        end else begin
          flushCnt_d = flushCnt_q + 4'd1;
        end
      end

      ST_REDIRECT: begin
        if (bus.pc_ack_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. The CP0 strobe fires on the first flush cycle only. With
  // EXL already set we are nested inside a handler, so the original EPC and
  // BD must survive; only ExcCode and EXL are touched. Data buses are held
  // at zero whenever they are not being written.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    flush   = 1'b0;
    cp0We   = 1'b0;
    epcWe   = 1'b0;
    epcData = 32'd0;
    excCode = 5'd0;
    causeBd = 1'b0;
    exlSet  = 1'b0;
    exlClr  = 1'b0;
    pcWe    = 1'b0;
    newPc   = 32'd0;

    case (state_q)
      ST_FLUSH: begin
        flush = 1'b1;
        if (flushCnt_q == 4'd0) begin
          cp0We = 1'b1;
          if (code_q == EXC_ERET) begin
            exlClr = 1'b1;
          end else begin
            exlSet  = 1'b1;
            excCode = mapExcCode(code_q);
            if (!exl_q) begin
              epcWe   = 1'b1;
              causeBd = bd_q;
              epcData = bd_q ? (pc_q - 32'd4) : pc_q;
            end
          end
        end
      end

      ST_REDIRECT: begin
        pcWe  = 1'b1;
        newPc = target_q;
      end

      default: begin
      end
    endcase
  end

  assign bus.busy_o          = busy;
  assign bus.flush_o         = flush;
  assign bus.cp0_we_o        = cp0We;
  assign bus.epc_we_o        = epcWe;
  assign bus.epc_o           = epcData;
  assign bus.cause_exccode_o = excCode;
  assign bus.cause_bd_o      = causeBd;
  assign bus.exl_set_o       = exlSet;
  assign bus.exl_clr_o       = exlClr;
  assign bus.pc_we_o         = pcWe;
  assign bus.new_pc_o        = newPc;

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl
//   Self-checking bench for exc_ctrl. Two instances share clock and reset:
//   dutA with FLUSH_CYCLES=1 and dutB with FLUSH_CYCLES=3. Inputs change on
//   the falling edge and outputs are sampled on the falling edge, half a
//   cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  exc_ctrl_if busA();
  exc_ctrl_if busB();

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vector: inputs for one exception on dutA plus the expected
  // CP0 update and redirect target.
  typedef struct {
    logic [3:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] status;
    logic [31:0] epcIn;
    logic        expEpcWe;
    logic [31:0] expEpc;
    logic [4:0]  expExcCode;
    logic        expBd;
    logic        expSet;
    logic        expClr;
    logic [31:0] expNewPc;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] pc,
                               input logic bd, input logic [31:0] status,
                               input logic [31:0] epcIn, input logic ack);
    busA.exc_code_i   = code;
    busA.exc_pc_i     = pc;
    busA.exc_bd_i     = bd;
    busA.cp0_status_i = status;
    busA.cp0_epc_i    = epcIn;
    busA.pc_ack_i     = ack;
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, ".busy"},    32'(busA.busy_o),          32'd0);
    checkOutput({tag, ".flush"},   32'(busA.flush_o),         32'd0);
    checkOutput({tag, ".cp0we"},   32'(busA.cp0_we_o),        32'd0);
    checkOutput({tag, ".epcwe"},   32'(busA.epc_we_o),        32'd0);
    checkOutput({tag, ".epc"},     busA.epc_o,                32'd0);
    checkOutput({tag, ".exccode"}, 32'(busA.cause_exccode_o), 32'd0);
    checkOutput({tag, ".bd"},      32'(busA.cause_bd_o),      32'd0);
    checkOutput({tag, ".exlset"},  32'(busA.exl_set_o),       32'd0);
    checkOutput({tag, ".exlclr"},  32'(busA.exl_clr_o),       32'd0);
    checkOutput({tag, ".pcwe"},    32'(busA.pc_we_o),         32'd0);
    checkOutput({tag, ".newpc"},   busA.new_pc_o,             32'd0);
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int flushCntB;
    int pcWeCntB;
    int cp0CntB;
    int firstPcWe;
    int unstable;
    int cp0AfterRst;

    checks = 0;
    errors = 0;

    //               code  pc            bd    status  epcIn         epcWe expEpc        exc    bd    set   clr   newPc
    vecs[0] = '{4'd9,  32'h0000_0100, 1'b0, 32'h0, 32'h0,         1'b1, 32'h0000_0100, 5'd8,  1'b0, 1'b1, 1'b0, 32'h0000_0020};
    vecs[1] = '{4'd12, 32'h0000_0204, 1'b1, 32'h0, 32'h0,         1'b1, 32'h0000_0200, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0000_0020};
    vecs[2] = '{4'd13, 32'h0000_0600, 1'b0, 32'h2, 32'h0000_0340, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 1'b1, 32'h0000_0340};
    vecs[3] = '{4'd10, 32'h0000_0500, 1'b1, 32'h2, 32'h0,         1'b0, 32'h0,         5'd10, 1'b0, 1'b1, 1'b0, 32'h0000_0020};
    vecs[4] = '{4'd11, 32'h0000_0000, 1'b1, 32'h0, 32'h0,         1'b1, 32'hFFFF_FFFC, 5'd13, 1'b1, 1'b1, 1'b0, 32'h0000_0020};
    vecs[5] = '{4'd8,  32'h0000_1234, 1'b0, 32'h1, 32'h0,         1'b1, 32'h0000_1234, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0000_0020};
    vecs[6] = '{4'd1,  32'h0000_0abc, 1'b1, 32'h3, 32'h0,         1'b0, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0, 32'h0000_0020};

    applyStimulus(4'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    busB.exc_code_i   = 4'd0;
    busB.exc_pc_i     = 32'd0;
    busB.exc_bd_i     = 1'b0;
    busB.cp0_status_i = 32'd0;
    busB.cp0_epc_i    = 32'd0;
    busB.pc_ack_i     = 1'b0;

    // Reset state, with a legal code presented to prove reset dominates.
    rst_n = 1'b0;
    busA.exc_code_i = 4'd9;
    repeat (3) @(negedge clk);
    checkAllZeroA("reset");
    checkOutput("reset.B.busy", 32'(busB.busy_o), 32'd0);
    checkOutput("reset.B.newpc", busB.new_pc_o, 32'd0);
    busA.exc_code_i = 4'd0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single exceptions on dutA, ack already high.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].code, vecs[i].pc, vecs[i].bd, vecs[i].status,
                    vecs[i].epcIn, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("v%0d.busy", i),   32'(busA.busy_o),    32'd1);
      checkOutput($sformatf("v%0d.flush", i),  32'(busA.flush_o),   32'd1);
      checkOutput($sformatf("v%0d.cp0we", i),  32'(busA.cp0_we_o),  32'd1);
      checkOutput($sformatf("v%0d.epcwe", i),  32'(busA.epc_we_o),  32'(vecs[i].expEpcWe));
      checkOutput($sformatf("v%0d.exlset", i), 32'(busA.exl_set_o), 32'(vecs[i].expSet));
      checkOutput($sformatf("v%0d.exlclr", i), 32'(busA.exl_clr_o), 32'(vecs[i].expClr));
      checkOutput($sformatf("v%0d.pcwe0", i),  32'(busA.pc_we_o),   32'd0);
      if (vecs[i].expEpcWe) begin
        checkOutput($sformatf("v%0d.epc", i), busA.epc_o,           vecs[i].expEpc);
        checkOutput($sformatf("v%0d.bd", i),  32'(busA.cause_bd_o), 32'(vecs[i].expBd));
      end
      if (vecs[i].expSet) begin
        checkOutput($sformatf("v%0d.exccode", i), 32'(busA.cause_exccode_o),
                    32'(vecs[i].expExcCode));
      end
      // Scramble the sources so the redirect must come from latched values.
      applyStimulus(4'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'h1111_0000, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("v%0d.pcwe", i),   32'(busA.pc_we_o),  32'd1);
      checkOutput($sformatf("v%0d.newpc", i),  busA.new_pc_o,      vecs[i].expNewPc);
      checkOutput($sformatf("v%0d.flush1", i), 32'(busA.flush_o),  32'd0);
      checkOutput($sformatf("v%0d.cp0we1", i), 32'(busA.cp0_we_o), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d.idle", i),   32'(busA.busy_o),   32'd0);
    end

    // Codes 14 and 15 behave as no exception.
    for (int c = 14; c <= 15; c++) begin
      applyStimulus(4'(c), 32'h0000_0100, 1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("code%0d.busy", c), 32'(busA.busy_o),   32'd0);
      checkOutput($sformatf("code%0d.cp0we", c), 32'(busA.cp0_we_o), 32'd0);
    end
    applyStimulus(4'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);

    // dutB: FLUSH_CYCLES=3, ack low for 5 redirect cycles, code 11 presented
    // throughout busy and still present on the handshake edge.
    busB.exc_code_i   = 4'd9;
    busB.exc_pc_i     = 32'h0000_0700;
    busB.cp0_status_i = 32'd0;
    busB.pc_ack_i     = 1'b0;
    flushCntB = 0;
    pcWeCntB  = 0;
    cp0CntB   = 0;
    firstPcWe = 0;
    unstable  = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (busB.flush_o) flushCntB++;
      if (busB.cp0_we_o) cp0CntB++;
      if (busB.pc_we_o) begin
        pcWeCntB++;
        if (firstPcWe == 0) firstPcWe = c;
        if (busB.new_pc_o !== 32'h0000_0020) unstable++;
      end
      if (c == 1) begin
        checkOutput("held.exccode", 32'(busB.cause_exccode_o), 32'd8);
        checkOutput("held.busy1",   32'(busB.busy_o),          32'd1);
        busB.exc_code_i = 4'd11;
      end
      if (c == 9) busB.pc_ack_i = 1'b1;
      if (c == 10) begin
        checkOutput("held.sameCycleIgnored", 32'(busB.busy_o), 32'd0);
        busB.exc_code_i = 4'd0;
        busB.pc_ack_i   = 1'b0;
      end
      if (c == 11) checkOutput("held.stillIdle", 32'(busB.busy_o), 32'd0);
    end
    checkOutput("held.flushCycles", 32'(flushCntB), 32'd3);
    checkOutput("held.pcWeCycles",  32'(pcWeCntB),  32'd6);
    checkOutput("held.cp0Pulses",   32'(cp0CntB),   32'd1);
    checkOutput("held.pcWeRise",    32'(firstPcWe), 32'd4);
    checkOutput("held.newPcStable", 32'(unstable),  32'd0);

    // Reset asserted during dutA's FLUSH cycle.
    applyStimulus(4'd9, 32'h0000_0100, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("rst.flushBefore", 32'(busA.flush_o), 32'd1);
    rst_n = 1'b0;
    applyStimulus(4'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkAllZeroA("rst");
    rst_n = 1'b1;
    cp0AfterRst = 0;
    repeat (3) begin
      @(negedge clk);
      if (busA.cp0_we_o || busA.busy_o) cp0AfterRst++;
    end
    checkOutput("rst.noLateStrobe", 32'(cp0AfterRst), 32'd0);

    // Fresh interrupt after reset.
    applyStimulus(4'd1, 32'h0000_0040, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("post.cp0we",   32'(busA.cp0_we_o),        32'd1);
    checkOutput("post.exccode", 32'(busA.cause_exccode_o), 32'd0);
    checkOutput("post.exlset",  32'(busA.exl_set_o),       32'd1);
    checkOutput("post.epc",     busA.epc_o,                32'h0000_0040);
    applyStimulus(4'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("post.newpc",   busA.new_pc_o,             32'h0000_0020);
    @(negedge clk);
    checkOutput("post.idle",    32'(busA.busy_o),          32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the pipelined CPU. Consumes the prioritised exception code from the MEM-stage encoder and runs the multi-cycle response: capture the faulting PC, flush the pipeline, update CP0 EPC/Cause/Status, and redirect fetch to the handler vector or, for ERET, to EPC. Sits between the MEM stage, CP0, and the fetch PC register.

## Interface
- `EXC_VECTOR`, default 32'h0000_0020: handler entry address.
- `FLUSH_CYCLES`, default 1: cycles `flush_o` is held; legal range 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `exc_code_i` in 4: encoder code. 0 = none, 1..8 = IP0..IP7, 9 = syscall, 10 = reserved instruction, 11 = trap, 12 = overflow, 13 = ERET. Values 14..15 are treated as 0.
- `exc_pc_i` in 32: PC of the MEM-stage instruction.
- `exc_bd_i` in 1: MEM-stage instruction is in a delay slot.
- `cp0_status_i` in 32: current Status.
- `cp0_epc_i` in 32: current EPC.
- `pc_ack_i` in 1: fetch accepted the redirect.
- `busy_o` out 1: sequence in progress.
- `flush_o` out 1: flush IF..MEM.
- `cp0_we_o` out 1: single-cycle CP0 update strobe.
- `epc_we_o` out 1: write EPC, qualified by `cp0_we_o`.
- `epc_o` out 32: EPC write data.
- `cause_exccode_o` out 5: Cause.ExcCode write data.
- `cause_bd_o` out 1: Cause.BD write data.
- `exl_set_o` out 1: set Status.EXL.
- `exl_clr_o` out 1: clear Status.EXL.
- `pc_we_o` out 1: redirect valid.
- `new_pc_o` out 32: redirect target.

## Operation
- States are IDLE, FLUSH, REDIRECT.
- IDLE, nonzero legal code: latch the code, PC, BD, the `cp0_status_i[1]` (EXL) value, and the target, then go to FLUSH. The target is `EXC_VECTOR`, or for ERET it is `cp0_epc_i` sampled at this same edge.
- FLUSH: `flush_o`=1 for exactly `FLUSH_CYCLES` cycles, counted by a 4-bit counter.
- FLUSH, first cycle only: `cp0_we_o`=1.
  - Exception or interrupt: `exl_set_o`=1 and `cause_exccode_o` is driven per the map below.
  - If the latched EXL was 0: `epc_we_o`=1, `cause_bd_o`=latched BD, and `epc_o` = BD ? PC−4 : PC (32-bit wraparound subtraction).
  - If the latched EXL was 1: EPC and BD are not written.
  - ERET: `exl_clr_o`=1 and `epc_we_o`=0.
- FLUSH, last cycle: go to REDIRECT.
- REDIRECT: `pc_we_o`=1 and `new_pc_o`=latched target, held stable until `pc_ack_i`. The state is left on the cycle where `pc_we_o`&&`pc_ack_i`, and the next state is IDLE.
- ExcCode map:
  - 1..8 → 0 (Int)
  - 9 → 8 (Sys)
  - 10 → 10 (RI)
  - 11 → 13 (Tr)
  - 12 → 12 (Ov)
- `exc_code_i` is ignored whenever state ≠ IDLE. A new code is accepted in IDLE on the cycle after the REDIRECT handshake, never in the same cycle as it.
- Reset values: state IDLE; every output 0, including `new_pc_o`, `epc_o` and `cause_exccode_o`.
- Reset mid-sequence: abandon the sequence and return to IDLE the next cycle. No CP0 strobe is issued after reset.

## Timing
- Code accepted at edge N: `busy_o`, `flush_o` and `cp0_we_o` are all 1 in cycle N+1.
- `flush_o` falls after cycle N+`FLUSH_CYCLES`.
- `pc_we_o` rises in cycle N+`FLUSH_CYCLES`+1.
- `busy_o` = (state ≠ IDLE). All outputs are registered state decodes; there is no combinational path from `exc_code_i`.
- `pc_ack_i` already high on REDIRECT entry: one-cycle REDIRECT. Minimum sequence is `FLUSH_CYCLES`+1 busy cycles.
- `pc_ack_i` is ignored outside REDIRECT.

## Structure
- Shared CPU package holds:
  - exception code constants (EXC_NONE, EXC_INT0..7, EXC_SYS, EXC_RI, EXC_TR, EXC_OV, EXC_ERET);
  - ExcCode constants;
  - Status bit indices (EXL=1, IE=0);
  - the state encoding.
- No sub-module. The ExcCode map is a local combinational function.

## Test plan
- **Syscall, no delay slot.** Code 9, PC 32'h0000_0100, BD=0, EXL=0.
  - Next cycle: `cp0_we_o`, `epc_we_o`=1, `epc_o`=32'h100, ExcCode 8, `exl_set_o`=1, `flush_o`=1.
  - Then `pc_we_o` with `new_pc_o`=32'h20.
- **Overflow in delay slot.** Code 12, PC 32'h0000_0204, BD=1.
  - `epc_o`=32'h200, `cause_bd_o`=1, ExcCode 12.
- **ERET.** Code 13, `cp0_epc_i`=32'h0000_0340.
  - `exl_clr_o`=1, `epc_we_o`=0, `new_pc_o`=32'h340.
- **Nested exception with EXL=1.** Code 10.
  - `cp0_we_o`=1, `epc_we_o`=0, ExcCode 10, redirect to 32'h20.
- **Held ack and ignored codes.** `FLUSH_CYCLES`=3, `pc_ack_i` held low 5 cycles, code 11 applied during busy.
  - `flush_o` high exactly 3 cycles.
  - `pc_we_o` and `new_pc_o` stable 6 cycles.
  - Code 11 is never accepted.
- **Reset mid-sequence.** `rst_n`=0 in the FLUSH cycle, then released.
  - All outputs are 0 the next cycle and no further `cp0_we_o` pulse occurs.
  - A fresh code 1 then yields ExcCode 0.
